// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the parametrised single-port SRAM.
// Optional output stage is controlled by SRAM_OUT_REG_EN in sram_param.
package sram_pkg;

  typedef enum logic {
    StClear = 1'b0,
    StIdle  = 1'b1
  } state_t;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 4;

  function automatic int unsigned calc_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic int unsigned calc_be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  localparam int unsigned DefDepth = calc_depth(DefAddrW);
  localparam int unsigned DefBeW   = calc_be_w(DefDataW);

endpackage

// File: rtl/sram_clear_seq.sv
// Clear sequencer: owns the CLEAR/IDLE state, the sweep counter and Busy.
// Drives a zeroing write port that the top muxes ahead of user writes.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam int unsigned Depth = calc_depth(ADDR_W);
  localparam logic [ADDR_W:0] LastCnt = (ADDR_W + 1)'(Depth - 1);

  state_t            r_state;
  logic [ADDR_W:0]   r_cnt;

  // Counter carries one extra bit so the terminal count never aliases to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StClear;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_state <= StClear;
      r_cnt   <= '0;
    end else if (r_state == StClear) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LastCnt) begin
        r_state <= StIdle;
      end
    end
  end

  assign o_busy     = (r_state == StClear);
  assign o_clr_we   = o_busy;
  assign o_clr_addr = r_cnt[ADDR_W-1:0];

endmodule

// File: rtl/sram_param.sv
// Parametrised single-port SRAM with byte enables, registered read and clear sweep.
// Define SRAM_OUT_REG_EN to add a second output register stage (2-cycle read).
module sram_param
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  localparam int unsigned BE_W  = calc_be_w(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic [BE_W-1:0]   i_byte_en,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_rd_valid,
  output logic              o_busy
);

  localparam int unsigned Depth = calc_depth(ADDR_W);

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_user_ok;
  logic              w_user_wr;
  logic              w_user_rd;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_wmask;

  logic [DATA_W-1:0] r_mem [Depth];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  sram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (i_clr),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // Clr in the same cycle drops the user access.
  assign w_user_ok = i_en && !w_busy && !i_clr;
  assign w_user_wr = w_user_ok && i_rw;
  assign w_user_rd = w_user_ok && !i_rw;

  assign w_we    = w_clr_we || w_user_wr;
  assign w_waddr = w_clr_we ? w_clr_addr : i_addr;
  assign w_wdata = w_clr_we ? '0 : i_data_in;
  assign w_wmask = w_clr_we ? '1 : i_byte_en;

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (w_wmask[i]) begin
          r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_user_rd;
      if (w_user_rd) begin
        r_rd_data <= r_mem[i_addr];
      end
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;

  // A Clr sampled while a read sits in the first stage flushes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_rd_valid && !i_clr;
      if (r_rd_valid && !i_clr) begin
        r_out_data <= r_rd_data;
      end
    end
  end

  assign o_data_out = r_out_data;
  assign o_rd_valid = r_out_valid;
`else
  assign o_data_out = r_rd_data;
  assign o_rd_valid = r_rd_valid;
`endif

  assign o_busy = w_busy;

endmodule

// File: tb/tb_sram_param.sv
// Self-checking bench for sram_param: scoreboard of expected reads against a model.
module tb_sram_param;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 4;
  localparam int unsigned Depth = 16;
`ifdef SRAM_OUT_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             rw;
  logic [AddrW-1:0] addr;
  logic [DataW-1:0] data_in;
  logic [3:0]       byte_en;
  logic             clr;
  logic [DataW-1:0] data_out;
  logic             rd_valid;
  logic             busy;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_mem [Depth];
  int          n_checks;
  int          n_errors;
  int          cyc;
  int          n_busy;

  sram_param #(
    .DATA_W (DataW),
    .ADDR_W (AddrW)
  ) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_rw       (rw),
    .i_addr     (addr),
    .i_data_in  (data_in),
    .i_byte_en  (byte_en),
    .i_clr      (clr),
    .o_data_out (data_out),
    .o_rd_valid (rd_valid),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      exp_t e;
      check_eq("rdv_while_busy", {31'd0, busy}, 32'd0);
      if (sb_q.size() == 0) begin
        check_eq("rdv_unexpected", {31'd0, rd_valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("rd_data", data_out, e.data);
        check_eq("rd_cycle", cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(Depth); i++) m_mem[i] = '0;
  endtask

  task automatic wr(input logic [AddrW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    en = 1'b1; rw = 1'b1; addr = a; data_in = d; byte_en = be;
    for (int i = 0; i < 4; i++) if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
    step();
    en = 1'b0;
  endtask

  task automatic rd(input logic [AddrW-1:0] a);
    exp_t e;
    en = 1'b1; rw = 1'b0; addr = a;
    e.data = m_mem[a];
    e.due  = cyc + Lat;
    sb_q.push_back(e);
    step();
    en = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain", sb_q.size(), 32'd0);
    step();
  endtask

  // Counts Busy-high cycles, bounded so a stuck sweep still reaches the summary.
  task automatic wait_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    step();
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    rst_n = 1'b0; en = 1'b0; rw = 1'b0; addr = '0; data_in = '0; byte_en = '0; clr = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd1);
    check_eq("rst_dout", data_out, 32'd0);
    check_eq("rst_rdv", {31'd0, rd_valid}, 32'd0);
    rst_n = 1'b1;
    wait_busy(n_busy);
    check_eq("busy_len_reset", n_busy, 32'd16);

    for (int i = 0; i < int'(Depth); i++) rd(AddrW'(i));
    drain();

    wr(4'd3, 32'hDEADBEEF, 4'hF);
    wr(4'd3, 32'h00001122, 4'b0001);
    wr(4'd7, 32'h12345678, 4'h0);
    rd(4'd3);
    rd(4'd7);
    drain();

    wr(4'd0, 32'h11, 4'hF);
    wr(4'd1, 32'h22, 4'hF);
    wr(4'd2, 32'h33, 4'hF);
    rd(4'd0);
    rd(4'd1);
    rd(4'd2);
    drain();
    check_eq("dout_hold", data_out, 32'h33);
    check_eq("rdv_idle", {31'd0, rd_valid}, 32'd0);

    // Clr and a write in the same cycle: the write must be dropped.
    clr = 1'b1; en = 1'b1; rw = 1'b1; addr = 4'd5; data_in = 32'hFFFFFFFF; byte_en = 4'hF;
    step();
    clr = 1'b0; en = 1'b0;
    model_clear();
    wait_busy(n_busy);
    check_eq("busy_len_clr", n_busy, 32'd16);
    rd(4'd5);
    rd(4'd3);
    drain();

    // Reset mid-sweep at count 7.
    wr(4'd10, 32'hAAAAAAAA, 4'hF);
    rd(4'd10);
    drain();
    check_eq("dout_pre_rst", data_out, 32'hAAAAAAAA);
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_clear();
    repeat (7) @(posedge clk);
    #1;
    check_eq("busy_mid_sweep", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_dout", data_out, 32'd0);
    check_eq("rst_async_rdv", {31'd0, rd_valid}, 32'd0);
    sb_q.delete();
    step();
    rst_n = 1'b1;
    wait_busy(n_busy);
    check_eq("busy_len_rst2", n_busy, 32'd16);
    rd(4'd10);
    drain();

    // Clr one cycle after a read: flushed when the output stage is present.
    wr(4'd2, 32'h33, 4'hF);
    rd(4'd2);
    clr = 1'b1;
`ifdef SRAM_OUT_REG_EN
    sb_q.delete();
`endif
    step();
    clr = 1'b0;
    model_clear();
    wait_busy(n_busy);
    check_eq("busy_len_clr2", n_busy, 32'd16);
    drain();
    rd(4'd2);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_param.md
# sram_param

Parametrised single-port synchronous SRAM for the MIPS GPP datapath, replacing the fixed 16×32 store with configurable width and depth. Adds per-byte write enables, a registered read with a valid strobe, and a hardware clear sequencer that zeroes the array one word per cycle. Busy is reported while the sweep runs. Sits behind the load/store unit as data memory or scratch RAM.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- BE_W, DATA_W/8, byte-enable width (derived, not overridden)

- Clk  in  1  clock, all state on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- En  in  1  access request, sampled each cycle
- RW  in  1  1 = write, 0 = read
- Addr  in  ADDR_W  word address
- Data_In  in  DATA_W  write data
- Byte_En  in  BE_W  per-byte write mask; bit i gates Data_In[8i+7:8i]
- Clr  in  1  synchronous request to start a clear sweep
- Data_Out  out  DATA_W  read data, held between reads
- Rd_Valid  out  1  one-cycle pulse, Data_Out updated this cycle
- Busy  out  1  clear sweep in progress; accesses ignored

## Operation
- FSM states: CLEAR, IDLE.
- Rst_n low forces the following:
  - state = CLEAR, sweep counter = 0
  - Data_Out = 0, Rd_Valid = 0, Busy = 1
  - Array contents are not reset directly.
- CLEAR:
  - Each cycle writes 0 to Memory[counter], then increments the counter.
  - After writing DEPTH−1, the next state is IDLE.
  - En is ignored and Rd_Valid stays 0.
- IDLE:
  - En=1, RW=1: write Memory[Addr], byte i updated only where Byte_En[i]=1. Byte_En=0 is a legal no-op.
  - En=1, RW=0: Data_Out <= Memory[Addr] and Rd_Valid pulses.
  - En=0: no change; Data_Out holds and Rd_Valid = 0.
  - Clr=1: next state CLEAR, counter = 0. Any access in the same cycle is dropped (Clr wins).
- Clr during CLEAR restarts the sweep at 0.
- Counter is ADDR_W+1 bits wide to detect the terminal count without wrap aliasing.
- Reads of a word return its last written value. Unwritten bytes keep their prior value.

## Timing
- Read latency is 1 cycle: Addr is sampled at edge N, Data_Out/Rd_Valid are valid after edge N (usable at edge N+1).
- Write takes effect at the sampling edge. A read of the same address in the next cycle returns the new data.
- Busy is high for exactly DEPTH cycles after Rst_n deasserts, and for DEPTH cycles after the edge that samples Clr.
- Busy is combinational from state (state==CLEAR).
- Rd_Valid is never high while Busy is high.
- Rst_n assertion mid-sweep or mid-read aborts immediately. Data_Out clears asynchronously.

## Configuration
- SRAM_OUT_REG_EN defined:
  - Adds a second output register stage.
  - Read latency becomes 2 cycles, and Rd_Valid is delayed identically.
  - Both stages reset to 0.
  - Clr or reset flushes the in-flight stage (Rd_Valid forced 0).
- SRAM_OUT_REG_EN undefined: single-stage read as specified above.

## Structure
- Package sram_pkg holds:
  - The state typedef (CLEAR, IDLE)
  - Localparam helpers for DEPTH and BE_W
- Sub-module sram_clear_seq holds the FSM, the sweep counter and Busy. It outputs the clear write-enable and clear address.
- The top level muxes between the clear path and the user path into a single array write port.

## Test plan
- Reset release with DATA_W=32, ADDR_W=4 -> Busy high for 16 cycles, then every address reads 0x00000000 with Rd_Valid pulsing once per read.
- Write 0xDEADBEEF to addr 3 (Byte_En=4'hF), then write 0x00001122 with Byte_En=4'b0001, then read addr 3 -> Data_Out=0xDEADBE22 one cycle after the read request.
- Back-to-back reads of addr 0, 1, 2 after writing 0x11, 0x22, 0x33 -> Data_Out sequence 0x11, 0x22, 0x33 on consecutive cycles with Rd_Valid held high for 3 cycles.
- Clr asserted in the same cycle as a write of 0xFFFFFFFF to addr 5 -> write dropped, Busy high 16 cycles, addr 5 reads 0.
- Rst_n pulsed low at sweep count 7, with 0xAAAAAAAA written to addr 10 before the Clr -> Data_Out=0 immediately, a fresh 16-cycle sweep follows, and addr 10 reads 0.
- With SRAM_OUT_REG_EN defined, a read of addr 2 holding 0x33 -> Rd_Valid and Data_Out=0x33 two cycles after the request. A Clr issued one cycle after the request suppresses the Rd_Valid.
